// File: rtl/pipe_stage_skid.sv
// Ready/valid pipeline-stage register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter for performance debug.
module pipe_stage_skid #(
    parameter int                DATA_W = 48,
    parameter bit                SKID   = 1'b1,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              h_valid;
    logic [DATA_W-1:0] h_data;
    logic              accept;
    logic              consume;

    assign accept    = in_valid & in_ready;
    assign consume   = h_valid & out_ready;
    assign out_valid = h_valid;
    // Empty head never exposes stale payload.
    assign out_data  = h_valid ? h_data : BUBBLE;

    generate
        if (SKID) begin : g_skid
            logic              s_valid;
            logic [DATA_W-1:0] s_data;

            // Registered ready: no combinational path from out_ready.
            assign in_ready = ~s_valid;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    h_valid <= 1'b0;
                    s_valid <= 1'b0;
                end else if (s_valid) begin
                    if (consume) s_valid <= 1'b0;
                end else if (!h_valid || consume) begin
                    h_valid <= accept;
                end else if (accept) begin
                    s_valid <= 1'b1;
                end
            end

            // Payload registers carry no reset; validity is tracked above.
            always_ff @(posedge clk) begin
                if (s_valid) begin
                    if (consume) h_data <= s_data;
                end else if (!h_valid || consume) begin
                    if (accept) h_data <= in_data;
                end else if (accept) begin
                    s_data <= in_data;
                end
            end
        end else begin : g_single
            assign in_ready = ~h_valid | out_ready;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    h_valid <= 1'b0;
                end else if (!h_valid || consume) begin
                    h_valid <= accept;
                end
            end

            always_ff @(posedge clk) begin
                if (accept && (!h_valid || consume)) h_data <= in_data;
            end
        end
    endgenerate

    // Flush deliberately leaves the counter alone; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (h_valid && !out_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance and a single-entry instance share
// stimulus; each is compared every cycle against a queue-based FIFO model.
module tb_pipe_stage_skid;

    localparam int          DW  = 16;
    localparam logic [15:0] BUB = 16'hB0B0;

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, flush;
    logic [DW-1:0] in_data;
    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [3:0]    stall_cnt1;
    logic [15:0]   stall_cnt0;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q0[$];
    int            cnt1 = 0;
    int            cnt0 = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b1), .BUBBLE(BUB), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt1)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1'b0), .BUBBLE(BUB), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each stage is a FIFO of capacity 2 (skid) or 1.
    function automatic bit ready_skid();
        return q1.size() < 2;
    endfunction

    function automatic bit ready_single();
        return (q0.size() == 0) || out_ready;
    endfunction

    always @(posedge clk) begin
        bit acc, cons;
        acc  = in_valid && ready_skid();
        cons = (q1.size() > 0) && out_ready;
        if (rst) begin
            q1.delete();
            cnt1 = 0;
        end else begin
            if (q1.size() > 0 && !out_ready && cnt1 < 15) cnt1++;
            if (flush) q1.delete();
            else begin
                if (cons) void'(q1.pop_front());
                if (acc) q1.push_back(in_data);
            end
        end

        acc  = in_valid && ready_single();
        cons = (q0.size() > 0) && out_ready;
        if (rst) begin
            q0.delete();
            cnt0 = 0;
        end else begin
            if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
            if (flush) q0.delete();
            else begin
                if (cons) void'(q0.pop_front());
                if (acc) q0.push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        if (checks > 0 || errors > 0) begin
            chk("skid_out_valid", 32'(out_valid1), 32'(q1.size() > 0));
            chk("skid_out_data", 32'(out_data1), 32'(q1.size() > 0 ? q1[0] : BUB));
            chk("skid_in_ready", 32'(in_ready1), 32'(ready_skid()));
            chk("skid_stall_cnt", 32'(stall_cnt1), 32'(cnt1));
            chk("single_out_valid", 32'(out_valid0), 32'(q0.size() > 0));
            chk("single_out_data", 32'(out_data0), 32'(q0.size() > 0 ? q0[0] : BUB));
            chk("single_in_ready", 32'(in_ready0), 32'(ready_single()));
            chk("single_stall_cnt", 32'(stall_cnt0), 32'(cnt0));
        end
    end

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic r);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 16'h0, 1, 0, 0);

        // Reset state.
        chk("rst_out_valid", 32'(out_valid1), 32'd0);
        chk("rst_out_data", 32'(out_data1), 32'hB0B0);
        chk("rst_in_ready", 32'(in_ready1), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt1), 32'd0);

        // Streaming at full rate, one cycle latency.
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'h1111 + 16'(i), 1, 0, 0);
            chk("stream_data", 32'(out_data1), 32'h1111 + 32'(i));
            chk("stream_in_ready", 32'(in_ready1), 32'd1);
        end
        cyc(0, 16'h0, 1, 0, 0);
        chk("stream_drained", 32'(out_valid1), 32'd0);

        // Fill A,B and stall.
        cyc(1, 16'hAAAA, 0, 0, 0);
        cyc(1, 16'hBBBB, 0, 0, 0);
        chk("skid_full_ready", 32'(in_ready1), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1, 16'hCCCC, 0, 0, 0);
        chk("stall_head", 32'(out_data1), 32'hAAAA);
        chk("stall_cnt4", 32'(stall_cnt1), 32'd4);
        cyc(0, 16'h0, 1, 0, 0);
        chk("release_b", 32'(out_data1), 32'hBBBB);
        cyc(0, 16'h0, 1, 0, 0);
        chk("release_empty", 32'(out_valid1), 32'd0);

        // Flush while full, incoming C discarded.
        cyc(1, 16'hAAAA, 0, 0, 0);
        cyc(1, 16'hBBBB, 0, 0, 0);
        cyc(1, 16'hCCCC, 0, 1, 0);
        chk("flush_valid", 32'(out_valid1), 32'd0);
        chk("flush_data", 32'(out_data1), 32'hB0B0);
        chk("flush_ready", 32'(in_ready1), 32'd1);
        chk("flush_keeps_cnt", 32'(stall_cnt1), 32'd6);
        cyc(0, 16'h0, 1, 0, 0);
        chk("flush_no_c", 32'(out_valid1), 32'd0);

        // rst and flush together while full with stall_cnt=7.
        cyc(1, 16'hAAAA, 0, 0, 0);
        cyc(1, 16'hBBBB, 0, 0, 0);
        chk("pre_rst_cnt7", 32'(stall_cnt1), 32'd7);
        cyc(1, 16'hCCCC, 0, 1, 1);
        chk("rstfl_valid", 32'(out_valid1), 32'd0);
        chk("rstfl_data", 32'(out_data1), 32'hB0B0);
        chk("rstfl_cnt", 32'(stall_cnt1), 32'd0);

        // Saturation of a 4-bit counter.
        cyc(1, 16'h5A5A, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 16'h0, 0, 0, 0);
        chk("sat_cnt15", 32'(stall_cnt1), 32'd15);
        chk("sat_16bit", 32'(stall_cnt0), 32'd20);
        cyc(0, 16'h0, 1, 0, 1);

        // Single-entry: replace H in the same cycle with no bubble.
        cyc(1, 16'hAAAA, 0, 0, 0);
        in_valid = 1'b1; in_data = 16'hBBBB; out_ready = 1'b1;
        #1;
        chk("single_comb_ready", 32'(in_ready0), 32'd1);
        @(posedge clk);
        #1;
        chk("single_replace_data", 32'(out_data0), 32'hBBBB);
        chk("single_replace_valid", 32'(out_valid0), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 24) == 0),
                1'($urandom_range(0, 99) == 0));
        end
        cyc(0, 16'h0, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
